// File: rtl/byte_timer_pkg.sv
// rtl/byte_timer_pkg.sv - shared types and default constants for the byte timer
package byte_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int CLKS_PER_BIT_DEF  = 8;
  localparam int BITS_PER_BYTE_DEF = 8;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - programmable rollover counter with clear and enable
//
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   clear          synchronous clear to zero (wins over count_enable)
//   count_enable   advance the count by one
//   rollover_val   terminal value; the count restarts at 1 after reaching it
//   count_out      current count
//   rollover_flag  registered, high while count_out == rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_flag;

  always_comb begin
    next_count = count_out;
    if (clear) begin
      next_count = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        next_count = NUM_CNT_BITS'(1);
      end else begin
        next_count = count_out + NUM_CNT_BITS'(1);
      end
    end
    next_flag = !clear && (next_count == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end

endmodule

// File: rtl/byte_timer_ctrl.sv
// rtl/byte_timer_ctrl.sv - bit/byte timing controller for the serial receive path
//
// Optional feature macro: BYTE_TIMER_RESYNC_EN (start in RUN re-aligns the phase).
//
// Ports:
//   clk           system clock
//   n_rst         asynchronous active-low reset
//   start         start-of-bit-stream pulse from the edge detector
//   stop          end-of-packet / abort
//   busy          timer running (HALF or RUN)
//   shift_strobe  registered one-cycle sample strobe at the centre of each bit
//   bit_idx       index of the bit being strobed, 0..7
//   byte_done     registered one-cycle pulse the cycle after the last strobe of a byte
module byte_timer_ctrl
  import byte_timer_pkg::*;
#(
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter int CNT_BITS      = 4,
  parameter int BITS_PER_BYTE = BITS_PER_BYTE_DEF
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic       shift_strobe,
  output logic [2:0] bit_idx,
  output logic       byte_done
);

  localparam logic [CNT_BITS-1:0] HALF_VAL = CNT_BITS'(CLKS_PER_BIT / 2);
  localparam logic [CNT_BITS-1:0] FULL_VAL = CNT_BITS'(CLKS_PER_BIT);
  localparam logic [3:0]          BYTE_VAL = 4'(BITS_PER_BYTE);
  localparam logic [3:0]          LAST_BIT = 4'(BITS_PER_BYTE - 1);

  state_t state, next_state;

  logic                active;
  logic                resync;
  logic                phase_clear;
  logic                phase_en;
  logic                phase_roll;
  logic [CNT_BITS-1:0] phase_cnt;
  logic [CNT_BITS-1:0] phase_rv;
  logic                bit_clear;
  logic                bit_en;
  logic                bit_roll;
  logic [3:0]          bit_cnt;
  logic                strobe_d;
  logic                done_d;

  flex_counter #(.NUM_CNT_BITS(CNT_BITS)) u_phase_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (phase_clear),
    .count_enable  (phase_en),
    .rollover_val  (phase_rv),
    .count_out     (phase_cnt),
    .rollover_flag (phase_roll)
  );

  flex_counter #(.NUM_CNT_BITS(4)) u_bit_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (bit_clear),
    .count_enable  (bit_en),
    .rollover_val  (BYTE_VAL),
    .count_out     (bit_cnt),
    .rollover_flag (bit_roll)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      shift_strobe <= 1'b0;
      byte_done    <= 1'b0;
    end else begin
      state        <= next_state;
      shift_strobe <= strobe_d;
      byte_done    <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    resync     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) next_state = HALF;
      end
      HALF: begin
        if (stop) next_state = IDLE;
        else if (phase_roll) next_state = RUN;
      end
      RUN: begin
        if (stop) begin
          next_state = IDLE;
        end else begin
`ifdef BYTE_TIMER_RESYNC_EN
          if (start) begin
            next_state = HALF;
            resync     = 1'b1;
          end
`endif
        end
      end
      default: next_state = IDLE;
    endcase

    active   = (state != IDLE);
    phase_rv = (state == HALF) ? HALF_VAL : FULL_VAL;
    phase_en = active;
    // Counter is held at zero while idle, so the first count after start is
    // cycle 0; a resync clears it the same way so the next half-bit restarts.
    phase_clear = !active || stop || resync;
    bit_en      = active && shift_strobe;
    // bit_idx survives a resync: only idle/abort discard the partial byte.
    bit_clear   = !active || stop;
    // Strobe is registered, so it is requested one count before the target.
    strobe_d    = active && (phase_cnt == phase_rv - CNT_BITS'(1));
    done_d      = active && !stop && shift_strobe && (bit_cnt == LAST_BIT);
  end

  assign busy = (state != IDLE);
  // Once the bit counter reaches BITS_PER_BYTE the next strobe is bit 0 of a new byte.
  assign bit_idx = bit_roll ? 3'd0 : bit_cnt[2:0];

endmodule

// File: tb/tb_byte_timer_ctrl.sv
// tb/tb_byte_timer_ctrl.sv - directed self-checking bench for byte_timer_ctrl
module tb_byte_timer_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       stop;
  logic       busy;
  logic       shift_strobe;
  logic [2:0] bit_idx;
  logic       byte_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  byte_timer_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .shift_strobe (shift_strobe),
    .bit_idx      (bit_idx),
    .byte_done    (byte_done)
  );

  // Uninterrupted run with CLKS_PER_BIT=8: strobes at 4,12,20,...
  function automatic logic plain_strobe(input int k);
    return (k >= 4) && (((k - 4) % 8) == 0);
  endfunction

  function automatic logic [2:0] plain_idx(input int k);
    if (k <= 4) return 3'd0;
    return 3'(((k - 5) / 8 + 1) % 8);
  endfunction

  function automatic logic plain_done(input int k);
    return (k >= 5) && plain_strobe(k - 1) && (plain_idx(k - 1) == 3'd7);
  endfunction

  // Ends at the sampling point (negedge) of cycle 0.
  task automatic begin_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", busy); end
    vectors++; if (shift_strobe !== 1'b0) begin miscompares++; $display("FAIL reset strobe got %b want 0", shift_strobe); end
    vectors++; if (byte_done !== 1'b0) begin miscompares++; $display("FAIL reset byte_done got %b want 0", byte_done); end
    vectors++; if (bit_idx !== 3'd0) begin miscompares++; $display("FAIL reset bit_idx got %0d want 0", bit_idx); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    begin_run();
    for (int k = 0; k <= 130; k++) begin
      if (k > 0) @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b busy cycle %0d got %b want 1", k, busy); end
      vectors++; if (shift_strobe !== plain_strobe(k)) begin miscompares++; $display("FAIL b2b strobe cycle %0d got %b want %b", k, shift_strobe, plain_strobe(k)); end
      vectors++; if (bit_idx !== plain_idx(k)) begin miscompares++; $display("FAIL b2b bit_idx cycle %0d got %0d want %0d", k, bit_idx, plain_idx(k)); end
      vectors++; if (byte_done !== plain_done(k)) begin miscompares++; $display("FAIL b2b byte_done cycle %0d got %b want %b", k, byte_done, plain_done(k)); end
    end
    go_idle();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b idle busy got %b want 0", busy); end
  endtask

  task automatic test_start_with_stop();
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_stop busy cycle %0d got %b want 0", k, busy); end
      vectors++; if (shift_strobe !== 1'b0) begin miscompares++; $display("FAIL start_stop strobe cycle %0d got %b want 0", k, shift_strobe); end
      @(negedge clk);
    end
  endtask

  task automatic test_abort(input int stop_edge, input string tag);
    logic       e_busy, e_strobe, e_done;
    logic [2:0] e_idx;
    begin_run();
    for (int k = 0; k <= stop_edge + 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k < stop_edge) begin
        e_busy = 1'b1; e_strobe = plain_strobe(k); e_idx = plain_idx(k); e_done = plain_done(k);
      end else begin
        // A strobe registered on the stop edge itself is still visible.
        e_busy = 1'b0; e_strobe = (k == stop_edge) && plain_strobe(k); e_idx = 3'd0; e_done = 1'b0;
      end
      vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL %s busy cycle %0d got %b want %b", tag, k, busy, e_busy); end
      vectors++; if (shift_strobe !== e_strobe) begin miscompares++; $display("FAIL %s strobe cycle %0d got %b want %b", tag, k, shift_strobe, e_strobe); end
      vectors++; if (bit_idx !== e_idx) begin miscompares++; $display("FAIL %s bit_idx cycle %0d got %0d want %0d", tag, k, bit_idx, e_idx); end
      vectors++; if (byte_done !== e_done) begin miscompares++; $display("FAIL %s byte_done cycle %0d got %b want %b", tag, k, byte_done, e_done); end
      stop = (k == stop_edge - 1);
    end
    stop = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int         next_s;
    logic       e_strobe;
    logic [2:0] e_idx;
`ifdef BYTE_TIMER_RESYNC_EN
    next_s = 24;
`else
    next_s = 28;
`endif
    begin_run();
    for (int k = 0; k <= next_s + 9; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= 20) begin
        e_strobe = plain_strobe(k); e_idx = plain_idx(k);
      end else begin
        e_strobe = (k == next_s) || (k == next_s + 8);
        e_idx = (k <= next_s) ? 3'd3 : ((k <= next_s + 8) ? 3'd4 : 3'd5);
      end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_start busy cycle %0d got %b want 1", k, busy); end
      vectors++; if (shift_strobe !== e_strobe) begin miscompares++; $display("FAIL busy_start strobe cycle %0d got %b want %b", k, shift_strobe, e_strobe); end
      vectors++; if (bit_idx !== e_idx) begin miscompares++; $display("FAIL busy_start bit_idx cycle %0d got %0d want %0d", k, bit_idx, e_idx); end
      vectors++; if (byte_done !== 1'b0) begin miscompares++; $display("FAIL busy_start byte_done cycle %0d got %b want 0", k, byte_done); end
      start = (k == 19);
    end
    start = 1'b0;
    go_idle();
  endtask

  task automatic test_reset_mid_byte();
    begin_run();
    repeat (30) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst pre busy got %b want 1", busy); end
    vectors++; if (bit_idx !== 3'd4) begin miscompares++; $display("FAIL midrst pre bit_idx got %0d want 4", bit_idx); end
    #2 n_rst = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy got %b want 0", busy); end
    vectors++; if (shift_strobe !== 1'b0) begin miscompares++; $display("FAIL midrst strobe got %b want 0", shift_strobe); end
    vectors++; if (byte_done !== 1'b0) begin miscompares++; $display("FAIL midrst byte_done got %b want 0", byte_done); end
    vectors++; if (bit_idx !== 3'd0) begin miscompares++; $display("FAIL midrst bit_idx got %0d want 0", bit_idx); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    begin_run();
    for (int k = 0; k <= 13; k++) begin
      if (k > 0) @(negedge clk);
      vectors++; if (shift_strobe !== plain_strobe(k)) begin miscompares++; $display("FAIL restart strobe cycle %0d got %b want %b", k, shift_strobe, plain_strobe(k)); end
      vectors++; if (bit_idx !== plain_idx(k)) begin miscompares++; $display("FAIL restart bit_idx cycle %0d got %0d want %0d", k, bit_idx, plain_idx(k)); end
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_start_with_stop();
    test_abort(30, "abort_mid");
    test_abort(60, "abort_last");
    test_start_while_busy();
    test_reset_mid_byte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
